// File: rtl/cp0_exc_ctrl.sv
// ---------------------------------------------------------------------------
// cp0_exc_ctrl
// Coprocessor-0 exception/interrupt controller for the 5-stage MIPS pipeline.
// Holds Status (12), Cause (13) and EPC (14). Samples the external interrupt
// lines into Cause.IP and arbitrates interrupts against EX-stage synchronous
// exceptions and eret. A taken event produces a one-cycle flush + redirect
// in the following cycle.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   int_               external interrupt lines (level)
//   ex_valid, ex_pc,   EX-stage instruction qualifier, PC and delay-slot flag
//   ex_in_delay
//   exc_syscall,       EX-stage exception sources and eret
//   exc_ri, exc_ov,
//   ex_eret
//   pipe_stall         load-use stall; events wait while it is high
//   cp0_we/waddr/wdata mtc0 write port
//   cp0_raddr/rdata    mfc0 read port (combinational)
//   flush, redirect,   one-cycle pipeline kill and PC reload
//   redirect_pc
// ---------------------------------------------------------------------------
module cp0_exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0008,
    parameter int          NUM_INT    = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_INT-1:0] int_,
    input  logic               ex_valid,
    input  logic [31:0]        ex_pc,
    input  logic               ex_in_delay,
    input  logic               exc_syscall,
    input  logic               exc_ri,
    input  logic               exc_ov,
    input  logic               ex_eret,
    input  logic               pipe_stall,
    input  logic               cp0_we,
    input  logic [4:0]         cp0_waddr,
    input  logic [31:0]        cp0_wdata,
    input  logic [4:0]         cp0_raddr,
    output logic [31:0]        cp0_rdata,
    output logic               flush,
    output logic               redirect,
    output logic [31:0]        redirect_pc
);

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic               ie_q, ie_d;
    logic               exl_q, exl_d;
    logic [NUM_INT-1:0] im_q, im_d;
    logic [NUM_INT-1:0] ip_q, ip_d;
    logic               bd_q, bd_d;
    logic [4:0]         exc_code_q, exc_code_d;
    logic [31:0]        epc_q, epc_d;
    logic [31:0]        redirect_pc_q, redirect_pc_d;

    logic [NUM_INT-1:0] int_pend;
    logic               go;
    logic               int_req;
    logic               exc_take;
    logic               eret_take;

    // Per-line pending: sampled request masked by its Status.IM bit.
    for (genvar gi = 0; gi < NUM_INT; gi++) begin : g_pend
        assign int_pend[gi] = ip_q[gi] & im_q[gi];
    end

    // Events only on a real, unstalled EX instruction so EPC names it.
    assign go        = ex_valid & ~pipe_stall & (state_q == IDLE);
    assign int_req   = ie_q & ~exl_q & (|int_pend);
    assign exc_take  = go & (int_req | exc_ri | exc_ov | exc_syscall);
    assign eret_take = go & ~(int_req | exc_ri | exc_ov | exc_syscall) & ex_eret;

    always_comb begin
        state_d       = state_q;
        ie_d          = ie_q;
        exl_d         = exl_q;
        im_d          = im_q;
        ip_d          = int_;
        bd_d          = bd_q;
        exc_code_d    = exc_code_q;
        epc_d         = epc_q;
        redirect_pc_d = redirect_pc_q;

        // mtc0 first; event updates below override the fields they touch.
        if (cp0_we) begin
            case (cp0_waddr)
                5'd12: begin
                    ie_d  = cp0_wdata[0];
                    exl_d = cp0_wdata[1];
                    im_d  = cp0_wdata[15:10];
                end
                5'd14:   epc_d = cp0_wdata;
                default: ;
            endcase
        end

        if (exc_take) begin
            // Nested exceptions keep the original return point.
            if (!exl_q) begin
                epc_d = ex_in_delay ? (ex_pc - 32'd4) : ex_pc;
                bd_d  = ex_in_delay;
            end
            exl_d = 1'b1;
            if (int_req)     exc_code_d = 5'd0;
            else if (exc_ri) exc_code_d = 5'd10;
            else if (exc_ov) exc_code_d = 5'd12;
            else             exc_code_d = 5'd8;
            redirect_pc_d = EXC_VECTOR;
            state_d       = FLUSH;
        end else if (eret_take) begin
            exl_d         = 1'b0;
            redirect_pc_d = epc_q;
            state_d       = FLUSH;
        end

        if (state_q == FLUSH) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            ie_q          <= 1'b0;
            exl_q         <= 1'b0;
            im_q          <= '0;
            ip_q          <= '0;
            bd_q          <= 1'b0;
            exc_code_q    <= 5'd0;
            epc_q         <= 32'd0;
            redirect_pc_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            ie_q          <= ie_d;
            exl_q         <= exl_d;
            im_q          <= im_d;
            ip_q          <= ip_d;
            bd_q          <= bd_d;
            exc_code_q    <= exc_code_d;
            epc_q         <= epc_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    always_comb begin
        cp0_rdata = 32'd0;
        case (cp0_raddr)
            5'd12:   cp0_rdata = {16'd0, im_q, 8'd0, exl_q, ie_q};
            5'd13:   cp0_rdata = {bd_q, 15'd0, ip_q, 3'd0, exc_code_q, 2'd0};
            5'd14:   cp0_rdata = epc_q;
            default: cp0_rdata = 32'd0;
        endcase
    end

    assign flush       = (state_q == FLUSH);
    assign redirect    = (state_q == FLUSH);
    assign redirect_pc = redirect_pc_q;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cp0_exc_ctrl
// Directed scenarios followed by randomized traffic. A reference model of the
// CP0 registers predicts each taken event and pushes the expected redirect
// target and cycle into a queue; an independent monitor pops and compares
// whenever the DUT pulses flush. Register contents are checked through the
// mfc0 port every cycle.
// ---------------------------------------------------------------------------
module tb_cp0_exc_ctrl;

    localparam logic [31:0] VEC = 32'h0000_0008;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  int_ = '0;
    logic        ex_valid = 0, ex_in_delay = 0;
    logic [31:0] ex_pc = '0;
    logic        exc_syscall = 0, exc_ri = 0, exc_ov = 0, ex_eret = 0;
    logic        pipe_stall = 0, cp0_we = 0;
    logic [4:0]  cp0_waddr = '0, cp0_raddr = '0;
    logic [31:0] cp0_wdata = '0;
    logic [31:0] cp0_rdata, redirect_pc;
    logic        flush, redirect;

    cp0_exc_ctrl #(.EXC_VECTOR(VEC), .NUM_INT(6)) dut (
        .clk(clk), .rst(rst), .int_(int_),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_in_delay(ex_in_delay),
        .exc_syscall(exc_syscall), .exc_ri(exc_ri), .exc_ov(exc_ov),
        .ex_eret(ex_eret), .pipe_stall(pipe_stall),
        .cp0_we(cp0_we), .cp0_waddr(cp0_waddr), .cp0_wdata(cp0_wdata),
        .cp0_raddr(cp0_raddr), .cp0_rdata(cp0_rdata),
        .flush(flush), .redirect(redirect), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [31:0] pc;
    } exp_t;
    exp_t exp_q[$];

    // Reference model: architectural register fields plus "an event was just
    // taken" (the next cycle belongs to the flush and accepts nothing).
    logic        m_ie, m_exl, m_bd, m_busy;
    logic [5:0]  m_im, m_ip;
    logic [4:0]  m_code;
    logic [31:0] m_epc;
    logic        n_ie, n_exl, n_bd, n_busy;
    logic [5:0]  n_im, n_ip;
    logic [4:0]  n_code;
    logic [31:0] n_epc;

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd12:   return {16'd0, m_im, 8'd0, m_exl, m_ie};
            5'd13:   return {m_bd, 15'd0, m_ip, 3'd0, m_code, 2'd0};
            5'd14:   return m_epc;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_ie = 0; m_exl = 0; m_bd = 0; m_busy = 0;
        m_im = '0; m_ip = '0; m_code = '0; m_epc = '0;
    endtask

    // Predict the effect of the clock edge that ends the current cycle.
    task automatic model_eval();
        bit go, intr, eret;
        int code;
        exp_t e;
        n_ie = m_ie; n_exl = m_exl; n_im = m_im; n_bd = m_bd;
        n_code = m_code; n_epc = m_epc; n_ip = int_;
        go   = ex_valid && !pipe_stall && !m_busy;
        intr = m_ie && !m_exl && ((m_ip & m_im) != 6'd0);
        code = -1;
        if (go) begin
            if (intr)             code = 0;
            else if (exc_ri)      code = 10;
            else if (exc_ov)      code = 12;
            else if (exc_syscall) code = 8;
        end
        eret = go && (code < 0) && ex_eret;
        if (cp0_we && cp0_waddr == 5'd12) begin
            n_ie = cp0_wdata[0]; n_exl = cp0_wdata[1]; n_im = cp0_wdata[15:10];
        end
        if (cp0_we && cp0_waddr == 5'd14) n_epc = cp0_wdata;
        if (code >= 0) begin
            if (!m_exl) begin
                n_epc = ex_in_delay ? ex_pc - 32'd4 : ex_pc;
                n_bd  = ex_in_delay;
            end
            n_exl  = 1'b1;
            n_code = 5'(code);
            e.cyc = cyc + 1; e.pc = VEC;
            exp_q.push_back(e);
        end else if (eret) begin
            n_exl = 1'b0;
            e.cyc = cyc + 1; e.pc = m_epc;
            exp_q.push_back(e);
        end
        n_busy = (code >= 0) || eret;
    endtask

    task automatic model_commit();
        m_ie = n_ie; m_exl = n_exl; m_im = n_im; m_ip = n_ip; m_bd = n_bd;
        m_code = n_code; m_epc = n_epc; m_busy = n_busy;
    endtask

    task automatic expect_reg(input string name, input logic [4:0] a, input logic [31:0] req);
        cp0_raddr = a;
        #1;
        n_vec++;
        if (cp0_rdata !== req) begin
            n_err++;
            $display("FAIL %s: cp0_rdata[%0d]=%h expected %h (t=%0t)", name, a, cp0_rdata, req, $time);
        end
    endtask

    // Advance one clock (inputs already driven at the negedge), then check
    // a register through mfc0 against the model.
    task automatic cycle();
        logic [4:0] a;
        model_eval();
        @(posedge clk);
        model_commit();
        @(negedge clk);
        case ($urandom_range(3))
            0: a = 5'd12;
            1: a = 5'd13;
            2: a = 5'd14;
            default: a = 5'($urandom);
        endcase
        expect_reg("model_reg", a, m_read(a));
    endtask

    task automatic clr();
        ex_valid = 0; ex_in_delay = 0; ex_pc = '0;
        exc_syscall = 0; exc_ri = 0; exc_ov = 0; ex_eret = 0;
        pipe_stall = 0; cp0_we = 0; cp0_waddr = '0; cp0_wdata = '0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        cp0_we = 1; cp0_waddr = a; cp0_wdata = d;
    endtask

    // Called at a negedge; holds rst for two edges and releases at a negedge.
    task automatic do_reset();
        rst = 1;
        exp_q.delete();
        clr();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        model_reset();
        #1;
        n_vec++;
        if (flush !== 1'b0 || redirect !== 1'b0 || redirect_pc !== 32'd0) begin
            n_err++;
            $display("FAIL reset_outputs: flush=%b redirect=%b redirect_pc=%h expected 0/0/0",
                     flush, redirect, redirect_pc);
        end
        expect_reg("reset_status", 12, 32'd0);
        expect_reg("reset_cause", 13, 32'd0);
        expect_reg("reset_epc", 14, 32'd0);
    endtask

    // Monitor: flush/redirect must match queued predictions, cycle-exact.
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (!rst) begin
            n_vec++;
            if (flush !== redirect) begin
                n_err++;
                $display("FAIL pulse_pair: flush=%b redirect=%b expected equal", flush, redirect);
            end
            if (flush === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL spurious_flush: flush=1 at cycle %0d expected 0", cyc);
                end else begin
                    e = exp_q.pop_front();
                    n_vec++;
                    if (e.cyc != cyc || redirect_pc !== e.pc) begin
                        n_err++;
                        $display("FAIL event: cycle=%0d redirect_pc=%h expected cycle=%0d redirect_pc=%h",
                                 cyc, redirect_pc, e.cyc, e.pc);
                    end
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                n_err++;
                $display("FAIL missing_flush: flush=0 at cycle %0d expected flush to %h", cyc, e.pc);
            end
        end
    end

    initial begin
        model_reset();
        @(negedge clk);
        do_reset();

        // Interrupt taken through IE/IM, one cycle after sampling.
        int_ = 6'b000001;
        mtc0(12, 32'h401); cycle(); clr();
        ex_valid = 1; ex_pc = 32'h20; cycle(); clr();
        cycle(); cycle();
        expect_reg("t2_epc", 14, 32'h20);
        expect_reg("t2_status", 12, 32'h403);
        expect_reg("t2_cause", 13, 32'h400);

        // Interrupt deferred across a stall.
        mtc0(12, 32'h401); cycle(); clr();
        ex_valid = 1; pipe_stall = 1; ex_pc = 32'h100; cycle(); cycle();
        pipe_stall = 0; ex_pc = 32'h24; cycle(); clr();
        cycle(); cycle();
        expect_reg("t3_epc", 14, 32'h24);

        // Overflow in a delay slot.
        int_ = 6'b0;
        mtc0(12, 32'h401); cycle(); clr();
        exc_ov = 1; ex_in_delay = 1; ex_valid = 1; ex_pc = 32'h44; cycle(); clr();
        cycle(); cycle();
        expect_reg("t4_epc", 14, 32'h40);
        expect_reg("t4_cause", 13, 32'h8000_0030);

        // eret, then a pending interrupt waits out the flush cycle.
        int_ = 6'b000001;
        ex_valid = 1; ex_eret = 1; ex_pc = 32'h70; cycle();
        expect_reg("t5_eret_status", 12, 32'h401);
        ex_eret = 0; ex_pc = 32'h30; cycle(); cycle(); clr();
        int_ = 6'b0;
        cycle(); cycle();
        expect_reg("t5_epc", 14, 32'h30);
        expect_reg("t5_status", 12, 32'h403);
        expect_reg("t5_cause", 13, 32'h0);

        // Nested syscall keeps EPC; mtc0 EPC loses to a same-cycle exception.
        exc_syscall = 1; ex_valid = 1; ex_pc = 32'h60; cycle(); clr();
        cycle(); cycle();
        expect_reg("t6_epc_kept", 14, 32'h30);
        expect_reg("t6_cause_sys", 13, 32'h20);
        mtc0(12, 32'h401); cycle(); clr();
        mtc0(14, 32'h1234); exc_ri = 1; ex_valid = 1; ex_pc = 32'h50; cycle(); clr();
        cycle();
        expect_reg("t6_epc_ri", 14, 32'h50);
        expect_reg("t6_cause_ri", 13, 32'h28);

        // Reset while in the flush cycle.
        exc_syscall = 1; ex_valid = 1; ex_pc = 32'h90; cycle(); clr();
        do_reset();
        cycle(); cycle();

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            clr();
            if ($urandom_range(99) < 5) int_ = 6'($urandom);
            ex_valid    = ($urandom_range(99) < 75);
            ex_pc       = {$urandom} & 32'hFFFF_FFFC;
            ex_in_delay = ($urandom_range(99) < 30);
            pipe_stall  = ($urandom_range(99) < 20);
            exc_syscall = ($urandom_range(99) < 8);
            exc_ri      = ($urandom_range(99) < 8);
            exc_ov      = ($urandom_range(99) < 8);
            ex_eret     = ($urandom_range(99) < 12);
            if ($urandom_range(99) < 15) begin
                case ($urandom_range(3))
                    0: mtc0(12, $urandom);
                    1: mtc0(13, $urandom);
                    2: mtc0(14, $urandom);
                    default: mtc0(5'($urandom), $urandom);
                endcase
            end
            if ($urandom_range(999) < 2) do_reset();
            else cycle();
        end

        clr();
        cycle(); cycle(); cycle();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL leftover_events: %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
